nic: RTL and testbench

- Network interface controller between one processing element (PE) and the PE port of a mesh router.
- PE side: memory-mapped register interface with one output-channel buffer and one input-channel buffer, each one packet deep.
- Router side: drives the router's PE input channel (send/ready/data) and terminates the router's PE output channel.
- Injection is gated by the router's even/odd polarity and the packet's virtual-channel bit.

---
 rtl/nic_if.sv | 28 ++
 rtl/nic.sv | 91 +++++++++
 tb/tb_nic.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/nic_if.sv
// PE register port plus router PE-channel signals of the network interface.
// The NIC takes the slave view; the PE/router side (or a bench) takes master.
interface nic_if #(
    parameter int DATA_WIDTH = 64
);
    logic [1:0]            addr;
    logic [DATA_WIDTH-1:0] d_in;
    logic [DATA_WIDTH-1:0] d_out;
    logic                  nicEn;
    logic                  nicWrEn;
    logic                  net_so;
    logic                  net_ri;
    logic [DATA_WIDTH-1:0] net_do;
    logic                  net_polarity;
    logic                  net_si;
    logic                  net_ro;
    logic [DATA_WIDTH-1:0] net_di;

    modport slave (
        input  addr, d_in, nicEn, nicWrEn, net_ri, net_polarity, net_si, net_di,
        output d_out, net_so, net_do, net_ro
    );

    modport master (
        output addr, d_in, nicEn, nicWrEn, net_ri, net_polarity, net_si, net_di,
        input  d_out, net_so, net_do, net_ro
    );
endinterface

// File: rtl/nic.sv
// Network interface controller: one-packet output and input buffers between a
// PE register port and a mesh router PE port, injection gated by VC polarity.
module nic #(
    parameter int DATA_WIDTH = 64,
    parameter int VC_BIT     = 63
) (
    input  logic  clk,
    input  logic  reset,
    nic_if.slave  bus
);
    localparam logic [1:0] ADDR_IBUF  = 2'b00;
    localparam logic [1:0] ADDR_ISTAT = 2'b01;
    localparam logic [1:0] ADDR_OBUF  = 2'b10;
    localparam logic [1:0] ADDR_OSTAT = 2'b11;

    logic [DATA_WIDTH-1:0] out_buf_q, out_buf_d;
    logic                  out_full_q, out_full_d;
    logic [DATA_WIDTH-1:0] in_buf_q, in_buf_d;
    logic                  in_full_q, in_full_d;
    logic [DATA_WIDTH-1:0] d_out_q, d_out_d;

    logic send;
    logic accept;
    logic pe_wr;
    logic pe_rd;

    // Both router handshakes are forced low while reset is held, even before
    // the first reset edge has cleared the flops.
    assign send   = reset & out_full_q & bus.net_ri &
                    (out_buf_q[VC_BIT] == bus.net_polarity);
    assign accept = reset & ~in_full_q & bus.net_si;

    assign bus.net_so = send;
    assign bus.net_ro = reset & ~in_full_q;
    assign bus.net_do = out_buf_q;
    assign bus.d_out  = d_out_q;

    assign pe_wr = bus.nicEn & bus.nicWrEn;
    assign pe_rd = bus.nicEn & ~bus.nicWrEn;

    always_comb begin
        out_buf_d  = out_buf_q;
        out_full_d = out_full_q;
        in_buf_d   = in_buf_q;
        in_full_d  = in_full_q;
        d_out_d    = d_out_q;

        // A write is only taken into an empty buffer; send implies full, so
        // a write on the draining edge is dropped.
        if (pe_wr && bus.addr == ADDR_OBUF && !out_full_q) begin
            out_buf_d  = bus.d_in;
            out_full_d = 1'b1;
        end else if (send) begin
            out_full_d = 1'b0;
        end

        if (accept) begin
            in_buf_d  = bus.net_di;
            in_full_d = 1'b1;
        end

        if (pe_rd) begin
            case (bus.addr)
                ADDR_IBUF: begin
                    d_out_d = in_buf_q;
                    if (in_full_q) in_full_d = 1'b0;
                end
                ADDR_ISTAT: d_out_d = DATA_WIDTH'(in_full_q);
                ADDR_OBUF:  d_out_d = '0;
                ADDR_OSTAT: d_out_d = DATA_WIDTH'(out_full_q);
                default:    d_out_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            out_buf_q  <= '0;
            out_full_q <= 1'b0;
            in_buf_q   <= '0;
            in_full_q  <= 1'b0;
            d_out_q    <= '0;
        end else begin
            out_buf_q  <= out_buf_d;
            out_full_q <= out_full_d;
            in_buf_q   <= in_buf_d;
            in_full_q  <= in_full_d;
            d_out_q    <= d_out_d;
        end
    end
endmodule

// File: tb/tb_nic.sv
// Scenario bench for nic: injected packets and PE reads are queued as
// expectations when driven and checked when the DUT produces them.
module tb_nic;
    localparam int DW = 64;

    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;

    logic [DW-1:0] exp_pkt[$];
    logic [DW-1:0] exp_rd[$];

    nic_if #(.DATA_WIDTH(DW)) ifc ();

    nic #(.DATA_WIDTH(DW), .VC_BIT(63)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.slave)
    );

    always #5 clk = ~clk;

    // Inputs change only just after posedge, so the values seen at negedge
    // are exactly those the next posedge will act on.
    always @(negedge clk) begin
        if (ifc.net_so === 1'b1) begin
            tests++;
            if (exp_pkt.size() == 0) begin
                fails++;
                $display("FAIL inject_unexpected: sent %h, none required", ifc.net_do);
            end else begin
                logic [DW-1:0] e;
                e = exp_pkt.pop_front();
                if (ifc.net_do !== e) begin
                    fails++;
                    $display("FAIL inject_data: got %h, required %h", ifc.net_do, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pe_write(input logic [1:0] a, input logic [DW-1:0] d);
        ifc.nicEn = 1'b1; ifc.nicWrEn = 1'b1; ifc.addr = a; ifc.d_in = d;
        tick();
        ifc.nicEn = 1'b0; ifc.nicWrEn = 1'b0;
    endtask

    task automatic pe_read(input logic [1:0] a, input logic [DW-1:0] e, input string nm);
        logic [DW-1:0] x;
        exp_rd.push_back(e);
        ifc.nicEn = 1'b1; ifc.nicWrEn = 1'b0; ifc.addr = a;
        tick();
        ifc.nicEn = 1'b0;
        x = exp_rd.pop_front();
        tests++;
        if (ifc.d_out !== x) begin
            fails++;
            $display("FAIL %s: d_out %h, required %h", nm, ifc.d_out, x);
        end
    endtask

    task automatic chk1(input logic got, input logic e, input string nm);
        tests++;
        if (got !== e) begin
            fails++;
            $display("FAIL %s: got %b, required %b", nm, got, e);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        ifc.net_si = 1'b1; ifc.net_di = 64'h1234;
        ifc.nicEn = 1'b1; ifc.nicWrEn = 1'b1; ifc.addr = 2'b10; ifc.d_in = 64'h77;
        ifc.net_ri = 1'b1; ifc.net_polarity = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk1(ifc.net_so, 1'b0, "reset_net_so");
            chk1(ifc.net_ro, 1'b0, "reset_net_ro");
        end
        tests++;
        if (ifc.d_out !== '0) begin
            fails++;
            $display("FAIL reset_d_out: got %h, required 0", ifc.d_out);
        end
        ifc.net_si = 1'b0; ifc.nicEn = 1'b0; ifc.nicWrEn = 1'b0;
        reset = 1'b1;
        #1;
        chk1(ifc.net_ro, 1'b1, "post_reset_net_ro");
        pe_read(2'b01, 64'h0, "reset_istat");
        pe_read(2'b11, 64'h0, "reset_ostat");
    endtask

    task automatic test_inject();
        ifc.net_ri = 1'b1; ifc.net_polarity = 1'b0;
        exp_pkt.push_back(64'h0000_0000_0000_00AA);
        pe_write(2'b10, 64'h0000_0000_0000_00AA);
        chk1(ifc.net_so, 1'b1, "inject_so_high");
        tick();
        chk1(ifc.net_so, 1'b0, "inject_so_one_cycle");
        pe_read(2'b11, 64'h0, "inject_ostat");
    endtask

    task automatic test_vc_mismatch();
        ifc.net_ri = 1'b1; ifc.net_polarity = 1'b0;
        exp_pkt.push_back(64'h8000_0000_0000_0055);
        pe_write(2'b10, 64'h8000_0000_0000_0055);
        chk1(ifc.net_so, 1'b0, "vc_hold_pol0");
        ifc.net_polarity = 1'b1; #1;
        chk1(ifc.net_so, 1'b1, "vc_send_pol1");
        tick();
        ifc.net_polarity = 1'b0; #1;
        chk1(ifc.net_so, 1'b0, "vc_after_send");
    endtask

    task automatic test_backpressure();
        ifc.net_ri = 1'b0; ifc.net_polarity = 1'b0;
        exp_pkt.push_back(64'h0000_0000_0000_00C3);
        pe_write(2'b10, 64'h0000_0000_0000_00C3);
        for (int i = 0; i < 5; i++) begin
            chk1(ifc.net_so, 1'b0, "bp_hold");
            if (i == 1) pe_write(2'b10, 64'h1);
            else tick();
        end
        pe_read(2'b11, 64'h1, "bp_ostat_full");
        ifc.net_ri = 1'b1; #1;
        chk1(ifc.net_so, 1'b1, "bp_release");
        tests++;
        if (ifc.net_do !== 64'h0000_0000_0000_00C3) begin
            fails++;
            $display("FAIL bp_original: net_do %h, required %h", ifc.net_do, 64'hC3);
        end
        tick();
        chk1(ifc.net_so, 1'b0, "bp_drained");
    endtask

    task automatic test_receive();
        chk1(ifc.net_ro, 1'b1, "rx_ready");
        ifc.net_si = 1'b1; ifc.net_di = 64'hDEAD_BEEF_0000_0001;
        tick();
        ifc.net_si = 1'b0; #1;
        chk1(ifc.net_ro, 1'b0, "rx_full");
        pe_read(2'b01, 64'h1, "rx_istat");
        pe_read(2'b00, 64'hDEAD_BEEF_0000_0001, "rx_data");
        chk1(ifc.net_ro, 1'b1, "rx_ready_again");
        pe_read(2'b00, 64'hDEAD_BEEF_0000_0001, "rx_stale");
        pe_read(2'b01, 64'h0, "rx_istat_empty");
    endtask

    task automatic test_overflow();
        ifc.net_si = 1'b1; ifc.net_di = 64'h5A;
        tick();
        ifc.net_di = 64'h2;
        tick();
        ifc.net_si = 1'b0; #1;
        chk1(ifc.net_ro, 1'b0, "ovf_still_full");
        pe_read(2'b00, 64'h5A, "ovf_first_kept");
    endtask

    task automatic test_back_to_back();
        // Write arriving on the draining edge is dropped.
        ifc.net_ri = 1'b0; ifc.net_polarity = 1'b0;
        exp_pkt.push_back(64'h11);
        pe_write(2'b10, 64'h11);
        ifc.net_ri = 1'b1;
        pe_write(2'b10, 64'h22);
        chk1(ifc.net_so, 1'b0, "b2b_write_dropped");
        pe_read(2'b11, 64'h0, "b2b_ostat");
        // Other addresses ignore writes; addr 10 reads zero.
        pe_write(2'b00, 64'hFF);
        pe_write(2'b11, 64'hFF);
        pe_read(2'b01, 64'h0, "wr_ignored_istat");
        pe_read(2'b11, 64'h0, "wr_ignored_ostat");
        pe_read(2'b10, 64'h0, "rd_obuf_zero");
        // Arrival during the clearing read waits one edge.
        ifc.net_si = 1'b1; ifc.net_di = 64'hA1;
        tick();
        ifc.net_di = 64'hB2;
        pe_read(2'b00, 64'hA1, "b2b_rx_first");
        chk1(ifc.net_ro, 1'b1, "b2b_ro_after_read");
        tick();
        ifc.net_si = 1'b0;
        pe_read(2'b00, 64'hB2, "b2b_rx_second");
        // Enable low holds d_out.
        ifc.addr = 2'b01; tick();
        tests++;
        if (ifc.d_out !== 64'hB2) begin
            fails++;
            $display("FAIL d_out_hold: got %h, required %h", ifc.d_out, 64'hB2);
        end
    endtask

    initial begin
        reset = 1'b0;
        ifc.addr = 2'b00; ifc.d_in = '0; ifc.nicEn = 1'b0; ifc.nicWrEn = 1'b0;
        ifc.net_ri = 1'b0; ifc.net_polarity = 1'b0; ifc.net_si = 1'b0; ifc.net_di = '0;
        #1;
        test_reset();
        test_inject();
        test_vc_mismatch();
        test_backpressure();
        test_receive();
        test_overflow();
        test_back_to_back();
        tick();
        tests++;
        if (exp_pkt.size() != 0) begin
            fails++;
            $display("FAIL inject_missing: %0d packets not sent, required 0", exp_pkt.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
